// File: rtl/sort_frame_loader_if.sv
// rtl/sort_frame_loader_if.sv - byte stream input and sorter-side frame bus for sort_frame_loader
interface sort_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] data_out1;
    logic [7:0] data_out2;
    logic [7:0] data_out3;
    logic [7:0] data_out4;
    logic [7:0] data_out5;
    logic [7:0] data_out6;
    logic [7:0] data_out7;
    logic [7:0] data_out8;
    logic       sort_ready;
    logic       sort_done;
    logic       sort_rst_n;

    modport slave (
        input  in_data, in_valid, in_last, sort_done,
        output in_ready, sort_ready, sort_rst_n,
        output data_out1, data_out2, data_out3, data_out4,
        output data_out5, data_out6, data_out7, data_out8
    );

    modport master (
        output in_data, in_valid, in_last, sort_done,
        input  in_ready, sort_ready, sort_rst_n,
        input  data_out1, data_out2, data_out3, data_out4,
        input  data_out5, data_out6, data_out7, data_out8
    );
endinterface

// File: rtl/sort_frame_loader.sv
// rtl/sort_frame_loader.sv - assembles 8-byte frames from a byte stream and sequences the insertion sorter
module sort_frame_loader #(
    parameter logic [7:0] PAD_VALUE = 8'hFF,
    parameter int         TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_frame_loader_if.slave    bus,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        SORT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    idx;
    logic [TW-1:0] timer;
    logic [7:0]    slot [8];
    logic          sort_rst_n_q;
    logic          accept;

    assign accept = (state == FILL) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR: state_next = FILL;
            FILL: begin
                if (accept) begin
                    if (idx == 3'd7)      state_next = SORT;
                    else if (bus.in_last) state_next = PAD;
                end
            end
            PAD:   if (idx == 3'd7) state_next = SORT;
            // A done arriving on the final allowed cycle still counts as success.
            SORT: begin
                if (bus.sort_done)            state_next = DONE;
                else if (timer == TIMER_LAST) state_next = CLEAR;
            end
            DONE:    state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= 3'd0;
            timer        <= '0;
            sort_rst_n_q <= 1'b0;
            err_timeout  <= 1'b0;
            for (int i = 0; i < 8; i++) slot[i] <= 8'h00;
        end else begin
            // The sorter is held in reset exactly while the loader sits in CLEAR.
            sort_rst_n_q <= (state_next != CLEAR);
            case (state)
                CLEAR: begin
                    idx   <= 3'd0;
                    timer <= '0;
                end
                FILL: begin
                    if (accept) begin
                        slot[idx] <= bus.in_data;
                        idx       <= idx + 3'd1;
                    end
                end
                PAD: begin
                    slot[idx] <= PAD_VALUE;
                    idx       <= idx + 3'd1;
                end
                SORT: begin
                    timer <= timer + 1'b1;
                    if (!bus.sort_done && (timer == TIMER_LAST)) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == FILL);
    assign bus.sort_ready = (state == SORT);
    assign bus.sort_rst_n = sort_rst_n_q;
    assign frame_done     = (state == DONE);
    assign busy           = (state == PAD) || (state == SORT) || (state == DONE);

    assign bus.data_out1 = slot[0];
    assign bus.data_out2 = slot[1];
    assign bus.data_out3 = slot[2];
    assign bus.data_out4 = slot[3];
    assign bus.data_out5 = slot[4];
    assign bus.data_out6 = slot[5];
    assign bus.data_out7 = slot[6];
    assign bus.data_out8 = slot[7];
endmodule

// File: tb/tb_sort_frame_loader.sv
// tb/tb_sort_frame_loader.sv - scoreboard bench for sort_frame_loader with a behavioural sorter stand-in
module tb_sort_frame_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_frame_loader_if bus ();
    logic frame_done;
    logic busy;
    logic err_timeout;

    sort_frame_loader #(.PAD_VALUE(8'hFF), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // Sorter stand-in: raises done on its 10th ready cycle after a re-arm.
    int   srt_cnt = 0;
    logic suppress_done = 1'b0;
    always @(posedge clk) begin
        if (!bus.sort_rst_n)     srt_cnt <= 0;
        else if (bus.sort_ready) srt_cnt <= srt_cnt + 1;
    end
    assign bus.sort_done = !suppress_done && (srt_cnt == 9);

    typedef struct {
        logic [63:0] slots;
        int          pads;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic [63:0] dout;
    assign dout = {bus.data_out8, bus.data_out7, bus.data_out6, bus.data_out5,
                   bus.data_out4, bus.data_out3, bus.data_out2, bus.data_out1};

    int   sr_run = 0, last_run = 0, pad_run = 0, low_run = 0, fd_count = 0;
    bit   low_rst = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (bus.sort_ready) sr_run++;
        else begin
            if (sr_run != 0) last_run = sr_run;
            sr_run = 0;
        end
        if (bus.in_ready) pad_run = 0;
        else if (busy && !bus.sort_ready && !frame_done) pad_run++;
        if (!bus.sort_rst_n) begin
            low_run++;
            if (rst) low_rst = 1;
        end else begin
            if (low_run > 0 && !low_rst) check("sort_rst_n_low_cycles", low_run, 1);
            low_run = 0;
            low_rst = 0;
        end
        if (frame_done) begin
            fd_count++;
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("frame_slots", dout, cur.slots);
                check("pad_cycles", pad_run, cur.pads);
            end
            check("sort_ready_cycles", last_run, 10);
        end
    end

    logic [7:0] frame_buf [8];

    // last_mode: 0 never flags in_last, 1 flags it on the final byte.
    task automatic send_frame(input int n, input bit rand_valid, input bit last_mode, input bit push);
        exp_t e;
        bit   aborted = 0;
        if (push) begin
            for (int i = 0; i < 8; i++) e.slots[8*i +: 8] = (i < n) ? frame_buf[i] : 8'hFF;
            e.pads = 8 - n;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n && !aborted; i++) begin
            int guard = 0;
            bit done = 0;
            while (!done) begin
                @(negedge clk);
                bus.in_data  = frame_buf[i];
                bus.in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (bus.in_valid) bus.in_last = last_mode && (i == n - 1);
                else              bus.in_last = 1'($urandom_range(0, 1));
                if (bus.in_valid && bus.in_ready) done = 1;
                else if (++guard > 200) begin
                    check("in_ready_wait", bus.in_ready, 1);
                    done = 1;
                    aborted = 1;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (g < 300 && !(exp_q.size() == 0 && bus.in_ready)) begin
            @(negedge clk);
            g++;
        end
        check("drain_bound", (exp_q.size() == 0) && bus.in_ready, 1);
    endtask

    task automatic load(input logic [63:0] v);
        for (int i = 0; i < 8; i++) frame_buf[i] = v[8*i +: 8];
    endtask

    initial begin
        int t1, t2, g, fd_before, n;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_data", dout, 64'h0);
        check("reset_ctrl", {bus.in_ready, bus.sort_ready, bus.sort_rst_n, frame_done, busy, err_timeout}, 0);
        rst = 1'b0;

        // Full frame, bytes listed slot 7 down to slot 0.
        load(64'h40_60_20_70_30_80_10_50);
        send_frame(8, 0, 0, 1);
        wait_idle();

        // Short frame padded from slot 3.
        load(64'h0);
        frame_buf[0] = 8'h05; frame_buf[1] = 8'h03; frame_buf[2] = 8'h09;
        send_frame(3, 0, 1, 1);
        wait_idle();

        // Back-to-back full frames: spacing between frame_done pulses.
        t1 = -1; t2 = -1;
        fork
            begin
                load(64'h11_22_33_44_55_66_77_88);
                send_frame(8, 0, 0, 1);
                load(64'h01_f0_02_e0_03_d0_04_c0);
                send_frame(8, 0, 1, 1);
            end
            begin
                for (g = 0; g < 200 && t2 < 0; g++) begin
                    @(negedge clk);
                    if (frame_done) begin
                        if (t1 < 0) t1 = g;
                        else        t2 = g;
                    end
                end
            end
        join
        check("frame_done_spacing", t2 - t1, 20);
        wait_idle();

        // Sorter never finishes: timeout, abort, back to FILL.
        suppress_done = 1'b1;
        fd_before = fd_count;
        load(64'hde_ad_be_ef_12_34_56_78);
        send_frame(8, 0, 0, 0);
        for (g = 0; g < 100 && !err_timeout; g++) @(negedge clk);
        for (g = 0; g < 20 && !bus.in_ready; g++) @(negedge clk);
        @(negedge clk);
        check("timeout_err", err_timeout, 1);
        check("timeout_in_ready", bus.in_ready, 1);
        check("timeout_sort_cycles", last_run, 16);
        check("timeout_no_frame_done", fd_count, fd_before);
        suppress_done = 1'b0;
        load(64'h08_07_06_05_04_03_02_01);
        send_frame(8, 0, 0, 1);
        wait_idle();
        check("err_sticky", err_timeout, 1);

        // Reset after 4 accepted bytes discards the partial frame.
        load(64'haa_bb_cc_dd_ee_ff_99_88);
        send_frame(4, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_data", dout, 64'h0);
        check("midreset_ctrl", {bus.in_ready, bus.sort_rst_n, busy, err_timeout}, 0);
        rst = 1'b0;
        load(64'h5a_4b_3c_2d_1e_0f_a5_b6);
        send_frame(8, 1, 0, 1);
        wait_idle();

        // Random lengths with in_valid toggling and stray in_last.
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) frame_buf[i] = 8'($urandom);
            send_frame(n, 1, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
